// File: rtl/temperature_link_pkg.sv
// -----------------------------------------------------------------------------
// temperature_link_pkg
// Shared definitions for the two-wire temperature link (sda data, scl clock).
// Both ends of the link agree on the default word width, the scl timing and
// the order in which bits leave the shift register.
//
// Contents:
//   DEFAULT_*   default parameter values for the transmitter
//   MSB_FIRST   bit order on the wire (1 = most significant bit first)
//   tx_state_e  transmitter FSM state encoding
// -----------------------------------------------------------------------------
package temperature_link_pkg;

    localparam int DEFAULT_TEMPERATURE_WIDTH = 16;
    localparam int DEFAULT_SCL_HALF_PERIOD   = 50;
    localparam int DEFAULT_INTER_WORD_GAP    = 8;
    localparam int DEFAULT_COUNT_WIDTH       = 16;

    // The receiver reassembles words by shifting left on every scl rise, so
    // the transmitter must put the most significant bit on the wire first.
    localparam bit MSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

endpackage : temperature_link_pkg

// File: rtl/temperature_serial_tx_scl_timebase.sv
// -----------------------------------------------------------------------------
// scl_timebase
// Down-counter used for both scl half-periods and the inter-word gap.
// A restart loads load_value; the counter then counts down to zero and
// raises tick for exactly one cycle when it reaches zero. A phase of N cycles
// is obtained by loading N-1. A restart on the tick cycle starts the next
// phase back-to-back, with no idle cycle in between.
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   restart     load load_value and start counting
//   load_value  value loaded on restart (phase length minus one)
//   tick        one-cycle pulse at terminal count
// -----------------------------------------------------------------------------
module scl_timebase #(
    parameter int CNT_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart,
    input  logic [CNT_WIDTH-1:0] load_value,
    output logic                 tick
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 running_q;
    logic                 running_d;

    // running_q keeps tick from firing repeatedly while the counter sits at 0.
    assign tick = running_q && (cnt_q == '0);

    always_comb begin
        cnt_d     = cnt_q;
        running_d = running_q;
        if (restart) begin
            cnt_d     = load_value;
            running_d = 1'b1;
        end else if (running_q) begin
            if (cnt_q == '0) begin
                running_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            running_q <= running_d;
        end
    end

endmodule : scl_timebase

// File: rtl/temperature_serial_tx.sv
// -----------------------------------------------------------------------------
// temperature_serial_tx
// Sensor-side transmitter for the two-wire temperature link. Accepts a
// parallel word over a valid/ready handshake and serialises it on sda with
// exactly TEMPERATURE_WIDTH rising scl edges, no framing bits. sda changes
// only together with a falling scl edge, so it is stable for the whole high
// phase. Between words scl and sda are held low for INTER_WORD_GAP cycles.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a word, scl=0, sda=0
// LOW   | scl low half-period, current bit already on sda
// HIGH  | scl high half-period, receiver samples sda on the rise
// GAP   | word finished, scl/sda low for INTER_WORD_GAP cycles
//
// Ports:
//   clk                system clock
//   reset              asynchronous active-low reset
//   temperatureValid   temperatureIn holds a word to send
//   temperatureIn      word to send, captured on handshake only
//   temperatureAccept  block can take a word this cycle
//   sda                serial data, registered
//   scl                serial clock, registered, idle low
//   busy               high from handshake until the gap ends
//   wordsSent          count of completed words, wraps silently
// -----------------------------------------------------------------------------
module temperature_serial_tx
    import temperature_link_pkg::*;
#(
    parameter int TEMPERATURE_WIDTH = DEFAULT_TEMPERATURE_WIDTH,
    parameter int SCL_HALF_PERIOD   = DEFAULT_SCL_HALF_PERIOD,
    parameter int INTER_WORD_GAP    = DEFAULT_INTER_WORD_GAP,
    parameter int COUNT_WIDTH       = DEFAULT_COUNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         temperatureValid,
    input  logic [TEMPERATURE_WIDTH-1:0] temperatureIn,
    output logic                         temperatureAccept,
    output logic                         sda,
    output logic                         scl,
    output logic                         busy,
    output logic [COUNT_WIDTH-1:0]       wordsSent
);

    // One timebase serves both the half-periods and the gap, so it is sized
    // for whichever of the two phases is longer.
    localparam int TB_MAX    = (SCL_HALF_PERIOD > INTER_WORD_GAP) ?
                               SCL_HALF_PERIOD : INTER_WORD_GAP;
    localparam int TB_WIDTH  = $clog2(TB_MAX);
    localparam int BIT_WIDTH = $clog2(TEMPERATURE_WIDTH + 1);

    localparam logic [TB_WIDTH-1:0]  HALF_LOAD = TB_WIDTH'(SCL_HALF_PERIOD - 1);
    localparam logic [TB_WIDTH-1:0]  GAP_LOAD  = TB_WIDTH'(INTER_WORD_GAP - 1);
    localparam logic [BIT_WIDTH-1:0] BIT_LOAD  = BIT_WIDTH'(TEMPERATURE_WIDTH);
    localparam logic [BIT_WIDTH-1:0] LAST_BIT  = BIT_WIDTH'(1);

    tx_state_e                    state_q;
    tx_state_e                    state_d;
    logic [TEMPERATURE_WIDTH-1:0] shift_q;
    logic [TEMPERATURE_WIDTH-1:0] shift_d;
    logic [TEMPERATURE_WIDTH-1:0] shift_next;
    logic [BIT_WIDTH-1:0]         bit_cnt_q;
    logic [BIT_WIDTH-1:0]         bit_cnt_d;
    logic                         sda_q;
    logic                         sda_d;
    logic                         scl_q;
    logic                         scl_d;
    logic                         busy_q;
    logic                         busy_d;
    logic                         accept_q;
    logic                         accept_d;
    logic [COUNT_WIDTH-1:0]       words_q;
    logic [COUNT_WIDTH-1:0]       words_d;

    logic                         tb_restart;
    logic [TB_WIDTH-1:0]          tb_load;
    logic                         tb_tick;

    logic                         handshake;

    assign handshake         = temperatureValid && accept_q;

    assign temperatureAccept = accept_q;
    assign sda               = sda_q;
    assign scl               = scl_q;
    assign busy              = busy_q;
    assign wordsSent         = words_q;

    scl_timebase #(
        .CNT_WIDTH (TB_WIDTH)
    ) u_timebase (
        .clk        (clk),
        .reset      (reset),
        .restart    (tb_restart),
        .load_value (tb_load),
        .tick       (tb_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        sda_d      = sda_q;
        scl_d      = scl_q;
        busy_d     = busy_q;
        accept_d   = accept_q;
        words_d    = words_q;
        tb_restart = 1'b0;
        tb_load    = HALF_LOAD;

        // The bit that follows the one currently on sda.
        shift_next = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

        case (state_q)
            ST_IDLE: begin
                scl_d    = 1'b0;
                sda_d    = 1'b0;
                accept_d = 1'b1;
                if (handshake) begin
                    shift_d    = temperatureIn;
                    sda_d      = MSB_FIRST ? temperatureIn[TEMPERATURE_WIDTH-1]
                                           : temperatureIn[0];
                    bit_cnt_d  = BIT_LOAD;
                    busy_d     = 1'b1;
                    accept_d   = 1'b0;
                    tb_restart = 1'b1;
                    state_d    = ST_LOW;
                end
            end

            ST_LOW: begin
                if (tb_tick) begin
                    scl_d      = 1'b1;
                    tb_restart = 1'b1;
                    state_d    = ST_HIGH;
                end
            end

            ST_HIGH: begin
                if (tb_tick) begin
                    scl_d      = 1'b0;
                    tb_restart = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        sda_d     = 1'b0;
                        shift_d   = '0;
                        bit_cnt_d = '0;
                        words_d   = words_q + COUNT_WIDTH'(1);
                        tb_load   = GAP_LOAD;
                        state_d   = ST_GAP;
                    end else begin
                        shift_d   = shift_next;
                        sda_d     = MSB_FIRST ? shift_next[TEMPERATURE_WIDTH-1]
                                              : shift_next[0];
                        bit_cnt_d = bit_cnt_q - BIT_WIDTH'(1);
                        state_d   = ST_LOW;
                    end
                end
            end

            ST_GAP: begin
                if (tb_tick) begin
                    busy_d   = 1'b0;
                    accept_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                scl_d    = 1'b0;
                sda_d    = 1'b0;
                busy_d   = 1'b0;
                accept_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            sda_q     <= 1'b0;
            scl_q     <= 1'b0;
            busy_q    <= 1'b0;
            accept_q  <= 1'b0;
            words_q   <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            sda_q     <= sda_d;
            scl_q     <= scl_d;
            busy_q    <= busy_d;
            accept_q  <= accept_d;
            words_q   <= words_d;
        end
    end

endmodule : temperature_serial_tx

// File: tb/tb_temperature_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_temperature_serial_tx
// Directed bench for the temperature link transmitter. A passive monitor
// plays the receiver: it samples sda on each scl rise and rebuilds words.
// A second, tiny instance exercises wordsSent wrap-around cheaply.
// Cycle numbering: cyc counts posedges; values checked #1 after an edge
// belong to the cycle that edge starts. A handshake edge is t0, so sda=MSB
// is seen at t0, the first rise at t0+H, the final fall at t0+2*H*W and
// temperatureAccept back high at t0+2*H*W+G.
// -----------------------------------------------------------------------------
module tb_temperature_serial_tx;

    localparam int W  = 16;
    localparam int H  = 4;
    localparam int G  = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid;
    logic [W-1:0]  din;
    logic          accept;
    logic          sda;
    logic          scl;
    logic          busy;
    logic [CW-1:0] words;

    logic          w_valid;
    logic [3:0]    w_din;
    logic          w_accept;
    logic          w_sda;
    logic          w_scl;
    logic          w_busy;
    logic [1:0]    w_words;

    always #5 clk = ~clk;

    temperature_serial_tx #(
        .TEMPERATURE_WIDTH (W),
        .SCL_HALF_PERIOD   (H),
        .INTER_WORD_GAP    (G),
        .COUNT_WIDTH       (CW)
    ) dut (
        .clk               (clk),
        .reset             (rst_n),
        .temperatureValid  (valid),
        .temperatureIn     (din),
        .temperatureAccept (accept),
        .sda               (sda),
        .scl               (scl),
        .busy              (busy),
        .wordsSent         (words)
    );

    temperature_serial_tx #(
        .TEMPERATURE_WIDTH (4),
        .SCL_HALF_PERIOD   (2),
        .INTER_WORD_GAP    (1),
        .COUNT_WIDTH       (2)
    ) dut_wrap (
        .clk               (clk),
        .reset             (rst_n),
        .temperatureValid  (w_valid),
        .temperatureIn     (w_din),
        .temperatureAccept (w_accept),
        .sda               (w_sda),
        .scl               (w_scl),
        .busy              (w_busy),
        .wordsSent         (w_words)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: sample on scl rise, MSB first, W rises per word.
    int           rise_total = 0;
    int           hs_cnt     = 0;
    int           stray      = 0;
    int           first_rise = -1;
    int           last_fall  = -1;
    int           bits       = 0;
    logic         prev_scl   = 1'b0;
    logic [W-1:0] shreg      = '0;
    logic [W-1:0] cap_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_scl = 1'b0;
            bits     = 0;
            shreg    = '0;
        end else begin
            if (scl && !prev_scl) begin
                if (!busy) stray++;
                if (bits == 0) first_rise = cyc;
                shreg = {shreg[W-2:0], sda};
                bits++;
                rise_total++;
                if (bits == W) begin
                    cap_q.push_back(shreg);
                    bits = 0;
                end
            end
            if (!scl && prev_scl) last_fall = cyc;
            prev_scl = scl;
            if (valid && accept) hs_cnt++;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_cap(input int idx);
        if (idx >= 0 && idx < cap_q.size()) return 32'(cap_q[idx]);
        return 32'bx;
    endfunction

    task automatic wait_accept(input int budget, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (accept === 1'b1) begin
                at_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_w_accept(input int budget, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (w_accept === 1'b1) begin
                at_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    logic [W-1:0] seq_words [3] = '{16'h0001, 16'hFFFF, 16'h8000};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int at;
        int base_rise;
        int base_hs;
        int ncap;
        int hs_e [3];

        rst_n   = 1'b0;
        valid   = 1'b0;
        din     = '0;
        w_valid = 1'b0;
        w_din   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_sda",     32'(sda),     32'd0);
        check("rst_scl",     32'(scl),     32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_accept",  32'(accept),  32'd0);
        check("rst_words",   32'(words),   32'd0);
        check("rst_w_words", 32'(w_words), 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("accept_after_reset", 32'(accept), 32'd1);

        // Single word A53C, valid for one cycle
        base_rise = rise_total;
        base_hs   = hs_cnt;
        ncap      = cap_q.size();
        valid = 1'b1;
        din   = 16'hA53C;
        @(posedge clk); #1;
        t0    = cyc;
        valid = 1'b0;
        din   = 16'h5555;
        check("t1_sda_msb",    32'(sda),    32'd1);
        check("t1_accept_low", 32'(accept), 32'd0);
        check("t1_busy",       32'(busy),   32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t1_scl_low_before_rise", 32'(scl), 32'd0);
        @(posedge clk); #1;
        check("t1_scl_first_rise", 32'(scl), 32'd1);
        wait_accept(200, at);
        check("t1_accept_return", 32'(at - t0),         32'd136);
        check("t1_first_rise",    32'(first_rise - t0), 32'd4);
        check("t1_last_fall",     32'(last_fall - t0),  32'd128);
        check("t1_rises",         32'(rise_total - base_rise), 32'd16);
        check("t1_word",          get_cap(ncap),        32'h0000A53C);
        check("t1_words_sent",    32'(words),           32'd1);
        check("t1_handshakes",    32'(hs_cnt - base_hs), 32'd1);
        check("t1_busy_end",      32'(busy),            32'd0);

        // Valid held high, three words back-to-back
        base_rise = rise_total;
        ncap      = cap_q.size();
        din   = seq_words[0];
        valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_accept(300, at);
            @(posedge clk); #1;
            hs_e[k] = cyc;
            if (k < 2) din = seq_words[k+1];
            else valid = 1'b0;
        end
        wait_accept(300, at);
        check("t2_spacing_01", 32'(hs_e[1] - hs_e[0]), 32'd137);
        check("t2_spacing_12", 32'(hs_e[2] - hs_e[1]), 32'd137);
        for (int k = 0; k < 3; k++) begin
            check("t2_word", get_cap(ncap + k), 32'(seq_words[k]));
        end
        check("t2_rises",      32'(rise_total - base_rise), 32'd48);
        check("t2_words_sent", 32'(words), 32'd4);

        // Input changes mid-word must not affect the word in flight
        base_hs = hs_cnt;
        ncap    = cap_q.size();
        din   = 16'h00FF;
        valid = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        repeat (19) @(posedge clk);
        #1;
        din = 16'h1234;
        wait_accept(200, at);
        valid = 1'b0;
        check("t3_handshakes", 32'(hs_cnt - base_hs), 32'd1);
        check("t3_word",       get_cap(ncap),         32'h000000FF);
        check("t3_words_sent", 32'(words),            32'd5);

        // Reset in the middle of a word
        din   = 16'hFFFF;
        valid = 1'b1;
        @(posedge clk); #1;
        t0    = cyc;
        valid = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("t4_pre_scl", 32'(scl), 32'd1);
        check("t4_pre_sda", 32'(sda), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_scl",    32'(scl),    32'd0);
        check("t4_rst_sda",    32'(sda),    32'd0);
        check("t4_rst_words",  32'(words),  32'd0);
        check("t4_rst_busy",   32'(busy),   32'd0);
        check("t4_rst_accept", 32'(accept), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("t4_accept_after_release", 32'(accept), 32'd1);
        base_rise = rise_total;
        ncap      = cap_q.size();
        din   = 16'h7E7E;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        wait_accept(200, at);
        check("t4_rises",      32'(rise_total - base_rise), 32'd16);
        check("t4_word",       get_cap(ncap),               32'h00007E7E);
        check("t4_words_sent", 32'(words),                  32'd1);

        // Twenty words of 1000 into the receiver model
        base_rise = rise_total;
        base_hs   = hs_cnt;
        ncap      = cap_q.size();
        din   = 16'd1000;
        valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wait_accept(300, at);
            @(posedge clk); #1;
        end
        valid = 1'b0;
        wait_accept(300, at);
        check("t5_handshakes", 32'(hs_cnt - base_hs),       32'd20);
        check("t5_rises",      32'(rise_total - base_rise), 32'd320);
        check("t5_words_sent", 32'(words),                  32'd21);
        for (int k = 0; k < 20; k++) begin
            check("t5_word", get_cap(ncap + k), 32'd1000);
        end
        check("t5_no_stray_rises", 32'(stray), 32'd0);

        // wordsSent wrap on the 2-bit counter instance
        for (int k = 0; k < 4; k++) begin
            w_din   = 4'(k + 5);
            w_valid = 1'b1;
            wait_w_accept(50, at);
            @(posedge clk); #1;
            t0      = cyc;
            w_valid = 1'b0;
            wait_w_accept(100, at);
            check("t6_word_time", 32'(at - t0),  32'd17);
            check("t6_wrap_count", 32'(w_words), 32'((k + 1) % 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_temperature_serial_tx
